kernel_host_loader: RTL and testbench
=====================================

// Module: kernel_host_loader
// PURPOSE
//  Upstream control stage for riscv_kernel. Streams a program image into imem and a data image into dmem over a valid/ready input.
//  Holds the kernel in reset while loading, then releases it and drives ap_start until ap_done.
//  Finally freezes the kernel and streams the full dmem contents back out over a valid/ready output.
//  Uses port 1 of the dual-port imem/dmem BRAMs; the kernel owns port 0.
// PARAMETERS
//  AddressWidth_imem  6    imem word-address width
//  AddressWidth_dmem  5    dmem word-address width
//  imem_size          40   program words loaded (<= 2**AddressWidth_imem)
//  dmem_size          32   data words loaded and read back (<= 2**AddressWidth_dmem)
//  DataWidth          32   word width
//  MaxCycles          4096 RUN-state timeout, in cycles
// PORTS
//  ap_clk         in   1    clock
//  ap_rst         in   1    synchronous reset, active-high
//  host_start     in   1    pulse: begin load/run/readback transaction
//  host_busy      out  1    high in every state except IDLE
//  host_done      out  1    1-cycle pulse after the last readback beat
//  host_timeout   out  1    sticky; set if RUN hit MaxCycles; cleared by accepted host_start
//  cycle_count    out  32   RUN cycles of last transaction; saturating
//  s_valid        in   1    input word valid
//  s_ready        out  1    input word accepted when s_valid&s_ready
//  s_data         in   DataWidth  input word: imem_size program words, then dmem_size data words
//  m_valid        out  1    readback word valid
//  m_ready        in   1    downstream ready
//  m_data         out  DataWidth  readback word, dmem[0..dmem_size-1] in order
//  m_last         out  1    high with the final readback word
//  imem_address1  out  AddressWidth_imem  imem write address
//  imem_ce1       out  1    imem port-1 enable
//  imem_we1       out  1    imem write enable
//  imem_d1        out  DataWidth  imem write data
//  dmem_address1  out  AddressWidth_dmem  dmem address
//  dmem_ce1       out  1    dmem port-1 enable
//  dmem_we1       out  1    dmem write enable
//  dmem_d1        out  DataWidth  dmem write data
//  dmem_q1        in   DataWidth  dmem read data; 1-cycle latency
//  kernel_rst     out  1    drives riscv_kernel ap_rst
//  kernel_start   out  1    drives riscv_kernel ap_start
//  kernel_done    in   1    riscv_kernel ap_done
// BEHAVIOUR
//  Reset state: IDLE; word counter = 0.
//   Outputs: kernel_rst=1; all others 0, including cycle_count and host_timeout.
//  FSM: IDLE -> LOAD_I -> LOAD_D -> RUN -> RD_ADDR -> RD_WAIT -> RD_OUT -> (RD_ADDR | IDLE).
//  IDLE
//   - s_ready=0; kernel_rst=1.
//   - host_start -> LOAD_I; cnt=0; host_timeout and cycle_count cleared.
//  LOAD_I
//   - s_ready=1.
//   - Each beat writes s_data into imem[cnt] in the same cycle: imem_ce1=imem_we1=1, combinational from the handshake. cnt++.
//   - Beat with cnt==imem_size-1 -> LOAD_D; cnt=0.
//  LOAD_D
//   - Same as LOAD_I, writing dmem[cnt].
//   - Beat with cnt==dmem_size-1 -> RUN; cycle counter=0.
//  RUN
//   - s_ready=0; kernel_rst=0; kernel_start=1; cycle_count++ each cycle.
//   - kernel_done is ignored in the first RUN cycle.
//   - kernel_done=1 -> RD_ADDR.
//   - cycle_count reaching MaxCycles-1 without kernel_done -> RD_ADDR with host_timeout=1.
//   - Both in the same cycle: kernel_done wins; no timeout.
//  RD_* states: kernel_rst=1, kernel_start=0 (kernel frozen). Readback loop:
//   - RD_ADDR: dmem_ce1=1, dmem_address1=cnt.
//   - RD_WAIT: capture dmem_q1 into the m_data register.
//   - RD_OUT: m_valid=1; m_last=(cnt==dmem_size-1).
//   - On m_ready in RD_OUT: cnt++ and return to RD_ADDR, or go to IDLE after the last word with host_done pulsed.
//   - Throughput: one word per 3 cycles.
//  Handshake rules
//   - m_data and m_last stay stable while m_valid && !m_ready.
//   - m_valid is never dropped without a handshake.
//   - Extra s_valid beats outside the LOAD states are not accepted.
//   - host_start is ignored while host_busy=1.
//  Other rules
//   - No writes occur outside LOAD_I/LOAD_D; imem/dmem ce/we are 0 otherwise.
//   - cnt is wide enough for max(imem_size, dmem_size); addresses are its low bits. No wrap beyond the size parameters.
//   - ap_rst mid-transaction: next cycle IDLE, kernel_rst=1, m_valid=0, no partial beat completes. Memory contents are left as written.
// STRUCTURE
//  Shared header/package:
//   - state encoding localparams (IDLE..RD_OUT, 3 bits)
//   - CNT_W = clog2(max(imem_size, dmem_size))
//  Single module. The counter and FSM are inline. The m_data/m_valid/m_last output register is small enough to stay inline; no sub-module required.
// TESTING
//  1. imem_size=4, dmem_size=4; stream 8 words 0xA0..0xA7; kernel_done forced high on RUN cycle 10.
//     -> imem[0..3]=A0..A3, dmem[0..3]=A4..A7, cycle_count=10.
//     -> Readback A4..A7 with m_last on the 4th word; host_done pulses once.
//  2. s_valid toggled 1-0-1 and m_ready held low 5 cycles per word.
//     -> No lost or duplicated word; m_data stable while stalled.
//  3. kernel_done never asserted, MaxCycles=16.
//     -> RUN exits after 16 cycles; host_timeout=1; readback still completes.
//  4. host_start pulsed during LOAD_D and RD_OUT.
//     -> Ignored; state sequence unchanged.
//  5. ap_rst asserted mid-LOAD_D at cnt=2.
//     -> Next cycle IDLE, kernel_rst=1, s_ready=0. A fresh host_start reloads from imem[0].
//  6. Full riscv_kernel integration with a program that stores 0x2A to dmem[3].
//     -> Readback word 3 == 0x2A; kernel_done terminates RUN.

Source files
------------

// File: rtl/kernel_host_loader_pkg.sv
// Shared types for the kernel host loader: FSM state encoding and counter sizing.
package kernel_host_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_I  = 3'd1,
    LOAD_D  = 3'd2,
    RUN     = 3'd3,
    RD_ADDR = 3'd4,
    RD_WAIT = 3'd5,
    RD_OUT  = 3'd6
  } state_t;

  // Word-counter width covering both image sizes; at least one bit.
  function automatic int cntWidth(input int imemSize, input int dmemSize);
    int m;
    m = (imemSize > dmemSize) ? imemSize : dmemSize;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/kernel_host_loader.sv
// Host-side control for riscv_kernel: loads imem/dmem over a stream, runs the
// kernel until done or timeout, then streams dmem back out.
module kernel_host_loader
  import kernel_host_loader_pkg::*;
#(
  parameter int AddressWidth_imem = 6,
  parameter int AddressWidth_dmem = 5,
  parameter int imem_size         = 40,
  parameter int dmem_size         = 32,
  parameter int DataWidth         = 32,
  parameter int MaxCycles         = 4096
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         host_start,
  output logic                         host_busy,
  output logic                         host_done,
  output logic                         host_timeout,
  output logic [31:0]                  cycle_count,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DataWidth-1:0]         s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DataWidth-1:0]         m_data,
  output logic                         m_last,
  output logic [AddressWidth_imem-1:0] imem_address1,
  output logic                         imem_ce1,
  output logic                         imem_we1,
  output logic [DataWidth-1:0]         imem_d1,
  output logic [AddressWidth_dmem-1:0] dmem_address1,
  output logic                         dmem_ce1,
  output logic                         dmem_we1,
  output logic [DataWidth-1:0]         dmem_d1,
  input  logic [DataWidth-1:0]         dmem_q1,
  output logic                         kernel_rst,
  output logic                         kernel_start,
  input  logic                         kernel_done
);

  localparam int CNT_W = cntWidth(imem_size, dmem_size);
  localparam logic [CNT_W-1:0] IM_LAST  = CNT_W'(imem_size - 1);
  localparam logic [CNT_W-1:0] DM_LAST  = CNT_W'(dmem_size - 1);
  localparam logic [31:0]      MAX_LAST = 32'(MaxCycles - 1);

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt;
  logic             inBeat, outBeat, imLast, dmLast, runTimeout, mLastR;

  // Writes are gated by reset so a beat coinciding with ap_rst never lands.
  assign s_ready = ((state == LOAD_I) || (state == LOAD_D)) && !ap_rst;
  assign inBeat  = s_valid && s_ready;
  assign m_valid = (state == RD_OUT);
  assign outBeat = m_valid && m_ready;
  assign m_last  = m_valid && mLastR;
  assign imLast  = (cnt == IM_LAST);
  assign dmLast  = (cnt == DM_LAST);

  assign host_busy    = (state != IDLE);
  assign kernel_rst   = (state != RUN);
  assign kernel_start = (state == RUN);

  assign imem_address1 = AddressWidth_imem'(cnt);
  assign imem_ce1      = inBeat && (state == LOAD_I);
  assign imem_we1      = imem_ce1;
  assign imem_d1       = s_data;
  assign dmem_address1 = AddressWidth_dmem'(cnt);
  assign dmem_we1      = inBeat && (state == LOAD_D);
  assign dmem_ce1      = dmem_we1 || (state == RD_ADDR);
  assign dmem_d1       = s_data;

  always_comb begin
    nextState  = state;
    runTimeout = 1'b0;
    case (state)
      IDLE:    if (host_start) nextState = LOAD_I;
      LOAD_I:  if (inBeat && imLast) nextState = LOAD_D;
      LOAD_D:  if (inBeat && dmLast) nextState = RUN;
      RUN: begin
        // kernel_done from the previous run may linger on the first cycle.
        if (kernel_done && (cycle_count != 32'd0)) begin
          nextState = RD_ADDR;
        end else if (cycle_count == MAX_LAST) begin
          nextState  = RD_ADDR;
          runTimeout = 1'b1;
        end
      end
      RD_ADDR: nextState = RD_WAIT;
      RD_WAIT: nextState = RD_OUT;
      RD_OUT:  if (outBeat) nextState = dmLast ? IDLE : RD_ADDR;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cycle_count  <= '0;
      host_timeout <= 1'b0;
      host_done    <= 1'b0;
      m_data       <= '0;
      mLastR       <= 1'b0;
    end else begin
      state     <= nextState;
      host_done <= outBeat && dmLast;
      case (state)
        IDLE: if (host_start) begin
          cnt          <= '0;
          cycle_count  <= '0;
          host_timeout <= 1'b0;
        end
        LOAD_I: if (inBeat) cnt <= imLast ? '0 : cnt + 1'b1;
        LOAD_D: if (inBeat) begin
          cnt <= dmLast ? '0 : cnt + 1'b1;
          if (dmLast) cycle_count <= '0;
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
          if (runTimeout) host_timeout <= 1'b1;
        end
        RD_WAIT: begin
          m_data <= dmem_q1;
          mLastR <= dmLast;
        end
        RD_OUT: if (outBeat) cnt <= dmLast ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_host_loader.sv
// Scoreboard bench for kernel_host_loader with behavioural BRAMs and a stub kernel.
module tb_kernel_host_loader;

  localparam int IS = 4;
  localparam int DS = 4;

  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        hsMain = 1'b0, hsRd = 1'b0;
  logic        host_start;
  logic        host_busy, host_done, host_timeout;
  logic [31:0] cycle_count;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic [31:0] m_data;
  logic [5:0]  imem_address1;
  logic        imem_ce1, imem_we1;
  logic [31:0] imem_d1;
  logic [4:0]  dmem_address1;
  logic        dmem_ce1, dmem_we1;
  logic [31:0] dmem_d1, dmem_q1 = '0;
  logic        kernel_rst, kernel_start, kernel_done;

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t expQ[$];

  logic [31:0] imemM [0:63];
  logic [31:0] dmemM [0:31];
  int  nChk = 0, nFail = 0;
  int  stall = 0, doneAt = 0, runIdx = 0, doneTotal = 0;
  bit  kernelWr = 0, rdPulse = 0;

  assign host_start  = hsMain | hsRd;
  assign kernel_done = kernel_start && (doneAt != 0) && (runIdx == doneAt - 1);

  always #5 clk = ~clk;

  kernel_host_loader #(
    .AddressWidth_imem(6), .AddressWidth_dmem(5), .imem_size(IS),
    .dmem_size(DS), .DataWidth(32), .MaxCycles(16)
  ) dut (
    .ap_clk(clk), .ap_rst(ap_rst), .host_start(host_start), .host_busy(host_busy),
    .host_done(host_done), .host_timeout(host_timeout), .cycle_count(cycle_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .imem_address1(imem_address1), .imem_ce1(imem_ce1), .imem_we1(imem_we1),
    .imem_d1(imem_d1), .dmem_address1(dmem_address1), .dmem_ce1(dmem_ce1),
    .dmem_we1(dmem_we1), .dmem_d1(dmem_d1), .dmem_q1(dmem_q1),
    .kernel_rst(kernel_rst), .kernel_start(kernel_start), .kernel_done(kernel_done)
  );

  // Port-1 BRAM models plus a stub kernel that may store 0x2A to dmem[3].
  initial begin
    for (int i = 0; i < 64; i++) imemM[i] = '0;
    for (int i = 0; i < 32; i++) dmemM[i] = '0;
  end
  always @(posedge clk) begin
    if (imem_ce1 && imem_we1) imemM[imem_address1] <= imem_d1;
    if (dmem_ce1) begin
      if (dmem_we1) dmemM[dmem_address1] <= dmem_d1;
      else dmem_q1 <= dmemM[dmem_address1];
    end
    if (kernelWr && kernel_start) dmemM[3] <= 32'h2A;
    runIdx <= kernel_start ? runIdx + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: drives m_ready with the configured stall and scores each beat.
  initial begin
    logic [31:0] heldD;
    logic        heldL;
    bit          stalled;
    int          sc;
    exp_t        e;
    heldD = '0; heldL = 1'b0; stalled = 0; sc = 0;
    forever begin
      @(negedge clk);
      if (host_done) doneTotal++;
      if (m_valid) begin
        if (stalled) begin
          check("m_data stable", m_data, heldD);
          check("m_last stable", {31'd0, m_last}, {31'd0, heldL});
        end
        if (sc < stall) begin m_ready = 1'b0; sc++; end
        else begin m_ready = 1'b1; sc = 0; end
        if (m_ready) begin
          stalled = 0;
          if (expQ.size() == 0) check("scoreboard underflow", 32'd1, 32'd0);
          else begin
            e = expQ.pop_front();
            check("m_data", m_data, e.d);
            check("m_last", {31'd0, m_last}, {31'd0, e.l});
          end
        end else begin
          stalled = 1; heldD = m_data; heldL = m_last;
        end
      end else begin
        if (stalled && !ap_rst) check("m_valid held", 32'd0, 32'd1);
        m_ready = 1'b0; stalled = 0; sc = 0;
      end
    end
  end

  // Pulses host_start once while a readback word is being presented.
  initial forever begin
    @(negedge clk);
    if (rdPulse && m_valid) begin
      hsRd = 1'b1;
      @(negedge clk);
      hsRd = 1'b0;
      rdPulse = 0;
    end
  end

  task automatic pulseStart();
    @(negedge clk); hsMain = 1'b1;
    @(posedge clk); #1 hsMain = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input bit gap);
    int t = 0;
    s_valid = 1'b1; s_data = w;
    @(negedge clk);
    while (!s_ready && t < 50) begin @(negedge clk); t++; end
    if (!s_ready) check("s_ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1 s_valid = 1'b0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!host_busy) break;
    end
    check("reached idle", {31'd0, host_busy}, 32'd0);
  endtask

  task automatic runTxn(input logic [31:0] base, input bit gap, input int stallN,
                        input int dAt, input bit kWr, input int expCyc,
                        input bit expTo, input int hsAt);
    int d0;
    stall = stallN; doneAt = dAt; kernelWr = kWr; d0 = doneTotal;
    for (int i = 0; i < DS; i++)
      expQ.push_back('{d: (kWr && i == 3) ? 32'h2A : base + 32'(IS + i), l: (i == DS - 1)});
    pulseStart();
    for (int i = 0; i < IS + DS; i++) begin
      if (i == hsAt) hsMain = 1'b1;
      send(base + 32'(i), gap);
      hsMain = 1'b0;
    end
    waitIdle();
    for (int i = 0; i < IS; i++) check("imem content", imemM[i], base + 32'(i));
    check("cycle_count", cycle_count, 32'(expCyc));
    check("host_timeout", {31'd0, host_timeout}, {31'd0, expTo});
    check("host_done pulses", 32'(doneTotal - d0), 32'd1);
    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    kernelWr = 0; doneAt = 0;
  endtask

  initial begin
    logic [31:0] prev;
    repeat (3) @(posedge clk);
    #1 ap_rst = 1'b0;
    @(negedge clk);
    check("rst kernel_rst", {31'd0, kernel_rst}, 32'd1);
    check("rst outputs", {23'd0, host_busy, host_done, host_timeout, s_ready, m_valid,
                          m_last, kernel_start, imem_ce1, dmem_ce1}, 32'd0);
    check("rst cycle_count", cycle_count, 32'd0);

    runTxn(32'hA0, 0, 0, 10, 0, 10, 0, -1);      // basic load/run/readback
    runTxn(32'h10, 1, 5, 4, 0, 4, 0, -1);        // gapped input, stalled output
    runTxn(32'h20, 0, 1, 0, 0, 16, 1, -1);       // timeout
    rdPulse = 1;
    runTxn(32'h30, 0, 0, 5, 0, 5, 0, IS);        // stray host_start pulses
    repeat (3) begin
      @(negedge clk);
      check("stays idle", {31'd0, host_busy}, 32'd0);
    end

    // Reset in LOAD_D with cnt==2 and a beat offered in the same cycle.
    pulseStart();
    for (int i = 0; i < IS + 2; i++) send(32'hC0 + 32'(i), 0);
    prev = dmemM[2];
    s_valid = 1'b1; s_data = 32'hDEAD; ap_rst = 1'b1;
    @(posedge clk); #1 ap_rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("abort idle", {31'd0, host_busy}, 32'd0);
    check("abort kernel_rst", {31'd0, kernel_rst}, 32'd1);
    check("abort s_ready", {31'd0, s_ready}, 32'd0);
    check("abort m_valid", {31'd0, m_valid}, 32'd0);
    check("abort no write", dmemM[2], prev);

    runTxn(32'h50, 0, 0, 3, 1, 3, 0, -1);        // reload + kernel store to dmem[3]

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
